frame_sync_rx: RTL

Parametrised successor to the fixed 40-bit data_valid receiver. It sits after iq_comb and takes the demodulated serial bitstream, qualified by sync_flag strobes. It hunts for a configurable frame header, collects payload and checksum, and checks the checksum in one of three selectable modes. It reports good and bad frames and timeouts, and keeps saturating frame and error counters for link monitoring.

---
 rtl/frame_sync_rx_if.sv | 31 +++
 rtl/frame_sync_rx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/frame_sync_rx_if.sv
// Bundle between the serial demod front end and the frame receiver: bit strobe in, frame
// status pulses, last good frame and link counters out.
interface frame_sync_rx_if #(
    parameter int FRAME_W = 40
);
    logic               ser_i;
    logic               sync_flag;
    logic               clr_cnt;
    logic               header_flag;
    logic               valid_flag;
    logic               err_flag;
    logic               timeout_flag;
    logic [FRAME_W-1:0] valid_data_o;
    logic [15:0]        frame_cnt;
    logic [15:0]        err_cnt;
    logic               state_dbg;

    // Strobe semantics: ser_i is taken on every clock where sync_flag=1, no handshake back;
    // every status flag is a one-clock pulse and at most one of valid/err/timeout is high.
    modport master (
        output ser_i, sync_flag, clr_cnt,
        input  header_flag, valid_flag, err_flag, timeout_flag,
        input  valid_data_o, frame_cnt, err_cnt, state_dbg
    );

    modport slave (
        input  ser_i, sync_flag, clr_cnt,
        output header_flag, valid_flag, err_flag, timeout_flag,
        output valid_data_o, frame_cnt, err_cnt, state_dbg
    );
endinterface

// File: rtl/frame_sync_rx.sv
// Serial frame receiver: hunts for HEADER in a strobed MSB-first bitstream, collects payload
// and checksum, validates it, and keeps saturating good/error counters.
module frame_sync_rx #(
    parameter int                  HEADER_W      = 8,
    parameter logic [HEADER_W-1:0] HEADER        = 8'hCC,
    parameter int                  PAYLOAD_BYTES = 3,
    parameter int                  CHK_MODE      = 0,
    parameter int                  TIMEOUT_CYC   = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    frame_sync_rx_if.slave bus
);
    localparam int FRAME_W = HEADER_W + 8 * PAYLOAD_BYTES + 8;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int FILL_W  = $clog2(HEADER_W + 1);
    localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic {HUNT, RECV} state_t;

    state_t             state;
    logic [HEADER_W-1:0] hdr_q;
    logic [FILL_W-1:0]   fill_q;
    logic [FRAME_W-1:0]  frame_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [TO_W-1:0]     to_cnt;

    logic [HEADER_W-1:0] hdr_next;
    logic [FRAME_W-1:0]  frame_next;
    logic [7:0]          sum;
    logic [7:0]          xr;
    logic                chk_ok;

    // Shift expressions written without slices so HEADER_W=1 stays legal.
    assign hdr_next   = (hdr_q << 1) | HEADER_W'(bus.ser_i);
    assign frame_next = (frame_q << 1) | FRAME_W'(bus.ser_i);
    assign bus.state_dbg = (state == RECV);

    always_comb begin
        sum = 8'd0;
        xr  = 8'd0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            sum = 8'(sum + frame_next[8 + 8 * i +: 8]);
            xr  = xr ^ frame_next[8 + 8 * i +: 8];
        end
        case (CHK_MODE)
            1:       chk_ok = (xr == frame_next[7:0]);
            2:       chk_ok = (8'(sum + frame_next[7:0]) == 8'd0);
            default: chk_ok = (sum == frame_next[7:0]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= HUNT;
            hdr_q            <= '0;
            fill_q           <= '0;
            frame_q          <= '0;
            bit_cnt          <= '0;
            to_cnt           <= '0;
            bus.header_flag  <= 1'b0;
            bus.valid_flag   <= 1'b0;
            bus.err_flag     <= 1'b0;
            bus.timeout_flag <= 1'b0;
            bus.valid_data_o <= '0;
            bus.frame_cnt    <= '0;
            bus.err_cnt      <= '0;
        end else begin
            bus.header_flag  <= 1'b0;
            bus.valid_flag   <= 1'b0;
            bus.err_flag     <= 1'b0;
            bus.timeout_flag <= 1'b0;

            // Counters follow the registered flags, so a clear in the flag cycle wins.
            if (bus.clr_cnt)
                bus.frame_cnt <= '0;
            else if (bus.valid_flag && bus.frame_cnt != 16'hFFFF)
                bus.frame_cnt <= bus.frame_cnt + 16'd1;

            if (bus.clr_cnt)
                bus.err_cnt <= '0;
            else if ((bus.err_flag || bus.timeout_flag) && bus.err_cnt != 16'hFFFF)
                bus.err_cnt <= bus.err_cnt + 16'd1;

            case (state)
                HUNT: begin
                    to_cnt <= '0;
                    if (bus.sync_flag) begin
                        if (fill_q >= FILL_W'(HEADER_W - 1) && hdr_next == HEADER) begin
                            bus.header_flag <= 1'b1;
                            state           <= RECV;
                            frame_q         <= FRAME_W'(HEADER);
                            bit_cnt         <= CNT_W'(HEADER_W);
                            hdr_q           <= '0;
                            fill_q          <= '0;
                        end else begin
                            hdr_q <= hdr_next;
                            if (fill_q < FILL_W'(HEADER_W))
                                fill_q <= fill_q + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bus.sync_flag) begin
                        to_cnt  <= '0;
                        frame_q <= frame_next;
                        if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                            if (chk_ok) begin
                                bus.valid_flag   <= 1'b1;
                                bus.valid_data_o <= frame_next;
                            end else begin
                                bus.err_flag <= 1'b1;
                            end
                            state   <= HUNT;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (TIMEOUT_CYC != 0 && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        bus.timeout_flag <= 1'b1;
                        state            <= HUNT;
                        to_cnt           <= '0;
                        bit_cnt          <= '0;
                        frame_q          <= '0;
                    end else if (TIMEOUT_CYC != 0) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule
